// File: rtl/piso_tx_if.sv
// Load handshake and serial output bundle for the piso_tx transmitter.
interface piso_tx_if #(
    parameter int unsigned WIDTH = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] din;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, din,
        input  load_ready, sout, sout_valid, busy, done
    );

    modport slave (
        input  load_valid, din,
        output load_ready, sout, sout_valid, busy, done
    );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: loads a word on valid/ready, shifts it out one bit per clk.
// Optional feature macro PISO_B2B_EN: accept the next word during the last-bit cycle (no gap).
module piso_tx #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    piso_tx_if.slave   bus
);
    localparam int unsigned     CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             last_c, load_ready_c, accept_c;

    assign last_c = (state_q == SHIFT) && (cnt_q == LAST);

`ifdef PISO_B2B_EN
    assign load_ready_c = (state_q == IDLE) || last_c;
`else
    assign load_ready_c = (state_q == IDLE);
`endif

    assign accept_c = bus.load_valid && load_ready_c;

    function automatic logic head(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    // Next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = SHIFT;
                    shift_d = bus.din;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (accept_c) begin
                    shift_d = bus.din;
                    cnt_d   = '0;
                end else begin
                    shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
                    if (last_c) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        sout_valid_d = (state_d == SHIFT);
        busy_d       = (state_d == SHIFT);
        done_d       = (state_d == SHIFT) && (cnt_d == LAST);
        sout_d       = (state_d == SHIFT) ? head(shift_d) : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.load_ready = load_ready_c;
    assign bus.sout       = sout_q;
    assign bus.sout_valid = sout_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: one MSB-first and one LSB-first instance against a stream model.
module tb_piso_tx;
    localparam int unsigned W = 4;
`ifdef PISO_B2B_EN
    localparam bit B2B = 1'b1;
    localparam int GAP = 0;
`else
    localparam bit B2B = 1'b0;
    localparam int GAP = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    piso_tx_if #(.WIDTH(W)) m_if ();
    piso_tx_if #(.WIDTH(W)) l_if ();

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(m_if));
    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(l_if));

    int n_total = 0;
    int n_pass  = 0;

    // Observation vectors: {sout, sout_valid, done, busy, load_ready}
    logic [4:0] obs_vec [64];
    logic [4:0] exp_vec [64];

    // Receiver model: shifts in only on valid cycles, MSB-first
    logic [W-1:0] sipo = '0;
    always @(posedge clk) if (m_if.sout_valid) sipo <= {sipo[W-2:0], m_if.sout};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v, input logic [W-1:0] d);
        if (sel) begin l_if.load_valid = v; l_if.din = d; end
        else     begin m_if.load_valid = v; m_if.din = d; end
    endtask

    function automatic logic [4:0] sample(input bit sel);
        if (sel) return {l_if.sout, l_if.sout_valid, l_if.done, l_if.busy, l_if.load_ready};
        return {m_if.sout, m_if.sout_valid, m_if.done, m_if.busy, m_if.load_ready};
    endfunction

    // Source holds each queued word on load_valid until accepted; obs_vec[i] is the cycle after edge i
    task automatic run(input bit sel, input logic [W-1:0] words[$], input int n);
        logic [W-1:0] q[$];
        bit acc;
        q = words;
        if (q.size() > 0) drive(sel, 1'b1, q[0]);
        else              drive(sel, 1'b0, W'($urandom));
        for (int i = 0; i < n; i++) begin
            acc = sel ? (l_if.load_valid && l_if.load_ready) : (m_if.load_valid && m_if.load_ready);
            tick();
            if (acc) void'(q.pop_front());
            if (q.size() > 0) drive(sel, 1'b1, q[0]);
            else              drive(sel, 1'b0, W'($urandom));
            obs_vec[i] = sample(sel);
        end
        drive(sel, 1'b0, '0);
    endtask

    // Expected stream: each word is W contiguous valid bits, words separated by gap idle cycles
    task automatic model(input bit msb, input logic [W-1:0] words[$], input int gap);
        int idx;
        logic [W-1:0] w;
        logic s, d;
        for (int i = 0; i < 64; i++) exp_vec[i] = 5'b00001;
        idx = 0;
        for (int k = 0; k < words.size(); k++) begin
            if (k > 0) idx += gap;
            w = words[k];
            for (int b = 0; b < int'(W); b++) begin
                s = msb ? w[int'(W) - 1 - b] : w[b];
                d = (b == int'(W) - 1);
                exp_vec[idx] = {s, 1'b1, d, 1'b1, B2B && d};
                idx++;
            end
        end
    endtask

    task automatic test_reset();
        logic [4:0] o;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            o = sample(s[0]);
            n_total++;
            if (o !== 5'b00001) $display("FAIL reset inst%0d: got %b want %b", s, o, 5'b00001);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] q[$];
        q = '{4'b1011};
        run(1'b0, q, 6);
        model(1'b1, q, GAP);
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (obs_vec[i] !== exp_vec[i])
                $display("FAIL basic cyc%0d: got %b want %b", i, obs_vec[i], exp_vec[i]);
            else n_pass++;
        end
    endtask

    task automatic test_loopback();
        logic [W-1:0] lw [3];
        logic [W-1:0] q[$];
        lw = '{4'b0110, 4'b1001, 4'b1111};
        for (int j = 0; j < 3; j++) begin
            q.delete();
            q.push_back(lw[j]);
            run(1'b0, q, int'(W) + 1);
            n_total++;
            if (sipo !== lw[j]) $display("FAIL loopback word%0d: got %b want %b", j, sipo, lw[j]);
            else n_pass++;
        end
    endtask

    task automatic test_busy_guard();
        logic [W-1:0] q[$];
        q = '{4'b1100, 4'b0011};
        run(1'b0, q, 11);
        model(1'b1, q, GAP);
        for (int i = 0; i < 11; i++) begin
            n_total++;
            if (obs_vec[i] !== exp_vec[i])
                $display("FAIL busy_guard cyc%0d: got %b want %b", i, obs_vec[i], exp_vec[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] q[$];
        logic [4:0] o;
        logic [4:0] want [3];
        want = '{5'b11010, 5'b01010, 5'b00001};
        drive(1'b0, 1'b1, 4'b1010);
        tick();
        drive(1'b0, 1'b0, 4'b1111);
        for (int c = 0; c < 3; c++) begin
            o = sample(1'b0);
            n_total++;
            if (o !== want[c]) $display("FAIL reset_mid cyc%0d: got %b want %b", c, o, want[c]);
            else n_pass++;
            if (c == 1) rst = 1'b1;
            if (c < 2) tick();
        end
        rst = 1'b0;
        q = '{4'b0101};
        run(1'b0, q, 6);
        model(1'b1, q, GAP);
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (obs_vec[i] !== exp_vec[i])
                $display("FAIL reset_mid_reload cyc%0d: got %b want %b", i, obs_vec[i], exp_vec[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q[$];
        q = '{4'b0001, 4'b1000};
        run(1'b1, q, 11);
        model(1'b0, q, GAP);
        for (int i = 0; i < 11; i++) begin
            n_total++;
            if (obs_vec[i] !== exp_vec[i])
                $display("FAIL back_to_back cyc%0d: got %b want %b", i, obs_vec[i], exp_vec[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [W-1:0] q[$];
        int k, n;
        bit sel;
        for (int it = 0; it < 8; it++) begin
            sel = it[0];
            k = $urandom_range(1, 3);
            q.delete();
            for (int j = 0; j < k; j++) q.push_back(W'($urandom));
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                drive(sel, 1'b0, W'($urandom));
                tick();
            end
            n = k * (int'(W) + 1) + 2;
            run(sel, q, n);
            model(!sel, q, GAP);
            for (int i = 0; i < n; i++) begin
                n_total++;
                if (obs_vec[i] !== exp_vec[i])
                    $display("FAIL random it%0d cyc%0d: got %b want %b", it, i, obs_vec[i], exp_vec[i]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        test_reset();
        test_basic();
        test_loopback();
        test_busy_guard();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end
endmodule
